byte_bus_bridge: RTL and testbench
==================================

Name: byte_bus_bridge

Overview:
- Downstream neighbour of data_io. Takes the lane-aligned 32-bit store word (data_io io_out) and returns a 32-bit read word (into data_io io_in).
- Serialises each access into byte transfers on an 8-bit external memory/peripheral bus with a request/ready handshake. Only the bytes the access needs are transferred.
- Reports completion and alignment or timeout faults to the control unit.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles one byte transfer may wait for mem_ready before a fault. 0 disables the timeout.

Ports:
- clock  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- load  input  1  read request; sampled only in IDLE
- store  input  1  write request; sampled only in IDLE
- data_type  input  3  access size: [1:0]=00 byte, 01 half, 1x word; bit 2 ignored (sign handled by data_io)
- address  input  32  byte address; [1:0] is the lane offset
- write_data  input  32  lane-aligned store data (data_io io_out)
- read_data  output  32  assembled lane-aligned load word (to data_io io_in)
- busy  output  1  high from the accept edge until the DONE or FAULT cycle ends
- done  output  1  one-cycle completion pulse
- fault  output  1  one-cycle pulse: misaligned access or timeout
- mem_address  output  32  byte address of the current transfer
- mem_write_data  output  8  byte driven on a write transfer
- mem_read_data  input  8  byte returned on a read transfer
- mem_request  output  1  transfer request; held until the handshake
- mem_write  output  1  1 = write transfer, 0 = read transfer
- mem_ready  input  1  target ready; a handshake occurs on any rising edge with mem_request && mem_ready

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE.
  - read_data = 0, busy = 0, done = 0, fault = 0.
  - mem_request = 0, mem_write = 0, mem_address = 0, mem_write_data = 0.
  - Reset mid-transfer drops mem_request in the same cycle. Nothing is completed or retried.
- States: IDLE, TRANSFER, DONE, FAULT.
- IDLE:
  - On an edge with load or store high, capture address, size, write_data and direction. If both are high, store wins.
  - A misaligned request goes to FAULT: half at offset 3, or word at offset other than 0. No bus activity is issued.
  - Otherwise go to TRANSFER. Byte count N = 1/2/4, start lane = address[1:0].
  - On accept, clear read_data to 0.
- TRANSFER:
  - mem_request = 1. mem_address = {address[31:2], lane}. mem_write = captured direction.
  - mem_write_data = write_data[8*lane+7 : 8*lane].
  - On each handshake:
    - Reads store mem_read_data into read_data lane `lane`. Other lanes stay 0.
    - Lane increments and the remaining count decrements.
    - After the Nth handshake, go to DONE. mem_request goes low on that edge.
- Wait and timeout:
  - The timeout counter resets at every handshake and increments on each cycle with mem_request && !mem_ready.
  - When TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES, go to FAULT and drop mem_request.
  - read_data keeps the bytes completed so far.
- DONE: done = 1 for exactly one cycle, then IDLE. load/store are not sampled in DONE.
- FAULT: fault = 1 for exactly one cycle, then IDLE. done stays 0.
- Latency with mem_ready tied high: done is high in the cycle that starts N edges after the accept edge (byte: 1, half: 2, word: 4).
- Stability:
  - busy is high in TRANSFER, DONE and FAULT.
  - load/store pulses while busy are ignored. They are neither queued nor merged.
  - read_data holds its value after DONE until the next accepted request.
  - mem_address and mem_write_data are stable while mem_request is high and unacknowledged.

Test Plan:
- Word store: address=0x100, write_data=0xDDCCBBAA, size=word, mem_ready=1 → four write transfers at 0x100..0x103 with bytes AA,BB,CC,DD; done pulses 4 cycles after accept; fault=0.
- Half load with wait states: address=0x202, size=half, mem_read_data 0x11 then 0x22, mem_ready low for 2 cycles before each byte → read_data=0x22110000, done after 6 cycles, only addresses 0x202 and 0x203 issued.
- Byte load at offset 3: address=0x7, mem_read_data=0x80 → single read at 0x7, read_data=0x80000000.
- Misaligned: word at 0x101, then half at 0x3 → fault pulses 1 cycle after each accept; mem_request never rises; done=0.
- Timeout with TIMEOUT_CYCLES=4 and mem_ready stuck 0 during a word load → fault after 4 waiting cycles; mem_request drops; state returns to IDLE. Next request with mem_ready=1 completes normally.
- Corner cases:
  - load and store both high → store is performed.
  - reset_n pulsed low during byte 2 of a word store → mem_request drops immediately; no done.
  - A load pulse while busy is ignored.

Source files
------------

// File: rtl/byte_bus_bridge.sv
// Serialises one lane-aligned 32-bit load/store into 1, 2 or 4 byte transfers on an
// 8-bit request/ready bus, assembling read bytes into their lanes and reporting done/fault.
module byte_bus_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        load,
   input  logic        store,
   input  logic [2:0]  data_type,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        busy,
   output logic        done,
   output logic        fault,
   output logic [31:0] mem_address,
   output logic [7:0]  mem_write_data,
   input  logic [7:0]  mem_read_data,
   output logic        mem_request,
   output logic        mem_write,
   input  logic        mem_ready
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_TRANSFER = 2'd1;
   localparam logic [1:0] S_DONE     = 2'd2;
   localparam logic [1:0] S_FAULT    = 2'd3;

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(TIMEOUT_CYCLES);

   logic [1:0]    state_q, state_d;
   logic [29:0]   word_addr_q, word_addr_d;
   logic [1:0]    lane_q, lane_d;
   logic [2:0]    left_q, left_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          write_q, write_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [TW-1:0] wait_q, wait_d;

   logic [2:0]    req_bytes;
   logic          misaligned;
   logic [TW-1:0] wait_inc;
   logic          unused_sign;

   // Sign extension lives in data_io; only the size bits matter here.
   assign unused_sign = data_type[2];

   always_comb begin
      req_bytes = 3'd4;
      case (data_type[1:0])
         2'b00:   req_bytes = 3'd1;
         2'b01:   req_bytes = 3'd2;
         default: req_bytes = 3'd4;
      endcase
   end

   assign misaligned = ((data_type[1:0] == 2'b01) && (address[1:0] == 2'b11)) ||
                       (data_type[1] && (address[1:0] != 2'b00));
   assign wait_inc   = wait_q + TW'(1);

   // NOTE: every next-state variable takes its current value first, so no path through the case infers a latch.
   always_comb begin
      state_d     = state_q;
      word_addr_d = word_addr_q;
      lane_d      = lane_q;
      left_d      = left_q;
      wdata_d     = wdata_q;
      write_d     = write_q;
      rdata_d     = rdata_q;
      wait_d      = wait_q;
      case (state_q)
         S_IDLE: begin
            if (load || store) begin
               word_addr_d = address[31:2];
               lane_d      = address[1:0];
               left_d      = req_bytes;
               wdata_d     = write_data;
               write_d     = store;
               rdata_d     = '0;
               wait_d      = '0;
               state_d     = misaligned ? S_FAULT : S_TRANSFER;
            end
         end
         S_TRANSFER: begin
            if (mem_ready) begin
               if (!write_q) begin
                  rdata_d[{lane_q, 3'b000} +: 8] = mem_read_data;
               end
               lane_d = lane_q + 2'd1;
               left_d = left_q - 3'd1;
               wait_d = '0;
               if (left_q == 3'd1) begin
                  state_d = S_DONE;
               end
            end else begin
               wait_d = wait_inc;
               if ((TIMEOUT_CYCLES != 0) && (wait_inc == TIMEOUT_LIMIT)) begin
                  state_d = S_FAULT;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         word_addr_q <= '0;
         lane_q      <= '0;
         left_q      <= '0;
         wdata_q     <= '0;
         write_q     <= 1'b0;
         rdata_q     <= '0;
         wait_q      <= '0;
      end else begin
         state_q     <= state_d;
         word_addr_q <= word_addr_d;
         lane_q      <= lane_d;
         left_q      <= left_d;
         wdata_q     <= wdata_d;
         write_q     <= write_d;
         rdata_q     <= rdata_d;
         wait_q      <= wait_d;
      end
   end

   assign read_data      = rdata_q;
   assign busy           = (state_q != S_IDLE);
   assign done           = (state_q == S_DONE);
   assign fault          = (state_q == S_FAULT);
   assign mem_request    = (state_q == S_TRANSFER);
   assign mem_write      = (state_q == S_TRANSFER) && write_q;
   assign mem_address    = {word_addr_q, lane_q};
   assign mem_write_data = wdata_q[{lane_q, 3'b000} +: 8];

endmodule

// File: tb/tb_byte_bus_bridge.sv
// Scoreboard bench for byte_bus_bridge: the driver queues expected bus transfers and
// responses; a negedge monitor plays the memory target and checks everything the DUT presents.
module tb_byte_bus_bridge;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        load, store;
   logic [2:0]  data_type;
   logic [31:0] address, write_data;
   logic [31:0] read_data;
   logic        busy, done, fault;
   logic [31:0] mem_address;
   logic [7:0]  mem_write_data;
   logic [7:0]  mem_read_data;
   logic        mem_request, mem_write;
   logic        mem_ready;

   byte_bus_bridge #(.TIMEOUT_CYCLES(4)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .load           (load),
      .store          (store),
      .data_type      (data_type),
      .address        (address),
      .write_data     (write_data),
      .read_data      (read_data),
      .busy           (busy),
      .done           (done),
      .fault          (fault),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data),
      .mem_request    (mem_request),
      .mem_write      (mem_write),
      .mem_ready      (mem_ready)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [7:0]  data;
   } bus_t;

   typedef struct {
      logic        is_fault;
      logic        chk_rd;
      logic [31:0] rd;
      int          lat;
   } resp_t;

   bus_t       bus_q[$];
   resp_t      resp_q[$];
   logic [7:0] rd_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int start_cyc = 0;
   int req_cycles = 0;
   int wait_cnt = 0;
   int wait_cycles = 0;
   logic stuck = 1'b0;
   logic busy_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_bus(input logic [31:0] a, input logic wr, input logic [7:0] d);
      bus_t b;
      b.addr = a; b.wr = wr; b.data = d;
      bus_q.push_back(b);
   endtask

   task automatic push_resp(input logic flt, input logic chk, input logic [31:0] rd, input int lat);
      resp_t r;
      r.is_fault = flt; r.chk_rd = chk; r.rd = rd; r.lat = lat;
      resp_q.push_back(r);
   endtask

   // Monitor and memory target: responses are checked, then mem_ready is decided for the next edge.
   always @(negedge clock) begin
      bus_t  b;
      resp_t r;
      cyc++;
      if (!reset_n) begin
         mem_ready = 1'b0;
         wait_cnt  = 0;
         busy_prev = 1'b0;
      end else begin
         if (busy && !busy_prev) start_cyc = cyc;
         busy_prev = busy;
         if (done || fault) begin
            if (resp_q.size() == 0) begin
               check("unexpected_response", {30'd0, done, fault}, 32'd0);
            end else begin
               r = resp_q.pop_front();
               check("resp_fault", {31'd0, fault}, {31'd0, r.is_fault});
               check("resp_done", {31'd0, done}, {31'd0, ~r.is_fault});
               check("resp_latency", 32'(cyc - start_cyc), 32'(r.lat));
               if (r.chk_rd) check("read_data", read_data, r.rd);
            end
         end
         if (mem_request) begin
            req_cycles++;
            if (stuck || wait_cnt < wait_cycles) begin
               mem_ready = 1'b0;
               wait_cnt++;
            end else begin
               mem_ready     = 1'b1;
               mem_read_data = (rd_q.size() != 0) ? rd_q[0] : 8'h00;
               wait_cnt      = 0;
               if (bus_q.size() == 0) begin
                  check("unexpected_transfer", mem_address, 32'hFFFF_FFFF);
               end else begin
                  b = bus_q.pop_front();
                  check("mem_address", mem_address, b.addr);
                  check("mem_write", {31'd0, mem_write}, {31'd0, b.wr});
                  if (b.wr) check("mem_write_data", {24'd0, mem_write_data}, {24'd0, b.data});
               end
               if (!mem_write && rd_q.size() != 0) void'(rd_q.pop_front());
            end
         end else begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
         end
      end
   end

   task automatic issue(input logic ld, input logic st, input logic [2:0] dt,
                        input logic [31:0] a, input logic [31:0] wd);
      @(negedge clock);
      load = ld; store = st; data_type = dt; address = a; write_data = wd;
      @(negedge clock);
      load = 1'b0; store = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (busy) check("idle_timeout", {31'd0, busy}, 32'd0);
      @(negedge clock);
   endtask

   initial begin
      int req_before;
      reset_n = 1'b0;
      load = 1'b0; store = 1'b0; data_type = 3'd0;
      address = '0; write_data = '0;
      mem_ready = 1'b0; mem_read_data = 8'h00;
      #12;
      check("rst_read_data", read_data, 32'd0);
      check("rst_flags", {28'd0, busy, done, fault, mem_request}, 32'd0);
      check("rst_mem_write", {31'd0, mem_write}, 32'd0);
      check("rst_mem_address", mem_address, 32'd0);
      check("rst_mem_wdata", {24'd0, mem_write_data}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;

      // Word store, ready tied high.
      wait_cycles = 0;
      push_bus(32'h100, 1'b1, 8'hAA); push_bus(32'h101, 1'b1, 8'hBB);
      push_bus(32'h102, 1'b1, 8'hCC); push_bus(32'h103, 1'b1, 8'hDD);
      push_resp(1'b0, 1'b0, 32'd0, 4);
      issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDDCC_BBAA);
      wait_idle();

      // Half load at offset 2 with two wait states per byte.
      wait_cycles = 2;
      rd_q.push_back(8'h11); rd_q.push_back(8'h22);
      push_bus(32'h202, 1'b0, 8'h00); push_bus(32'h203, 1'b0, 8'h00);
      push_resp(1'b0, 1'b1, 32'h2211_0000, 6);
      issue(1'b1, 1'b0, 3'b001, 32'h202, 32'd0);
      wait_idle();

      // Byte load at offset 3.
      wait_cycles = 0;
      rd_q.push_back(8'h80);
      push_bus(32'h7, 1'b0, 8'h00);
      push_resp(1'b0, 1'b1, 32'h8000_0000, 1);
      issue(1'b1, 1'b0, 3'b100, 32'h7, 32'd0);
      wait_idle();
      repeat (3) @(negedge clock);
      check("read_data_hold", read_data, 32'h8000_0000);

      // Misaligned word, then misaligned half: fault with no bus activity.
      req_before = req_cycles;
      push_resp(1'b1, 1'b0, 32'd0, 0);
      issue(1'b1, 1'b0, 3'b010, 32'h101, 32'd0);
      wait_idle();
      push_resp(1'b1, 1'b0, 32'd0, 0);
      issue(1'b1, 1'b0, 3'b001, 32'h3, 32'd0);
      wait_idle();
      check("misaligned_req_cycles", 32'(req_cycles - req_before), 32'd0);

      // Timeout: target never ready during a word load.
      stuck = 1'b1;
      req_before = req_cycles;
      push_resp(1'b1, 1'b1, 32'd0, 4);
      issue(1'b1, 1'b0, 3'b010, 32'h0, 32'd0);
      wait_idle();
      stuck = 1'b0;
      check("timeout_req_cycles", 32'(req_cycles - req_before), 32'd4);
      check("timeout_req_dropped", {31'd0, mem_request}, 32'd0);

      // Recovery after timeout: byte store at offset 1.
      push_bus(32'h41, 1'b1, 8'h5A);
      push_resp(1'b0, 1'b0, 32'd0, 1);
      issue(1'b0, 1'b1, 3'b000, 32'h41, 32'h0000_5A00);
      wait_idle();

      // Load and store together: the store is performed.
      push_bus(32'h10, 1'b1, 8'hEF); push_bus(32'h11, 1'b1, 8'hBE);
      push_resp(1'b0, 1'b0, 32'd0, 2);
      issue(1'b1, 1'b1, 3'b001, 32'h10, 32'h0000_BEEF);
      wait_idle();

      // Word load with a stray load pulse while busy.
      rd_q.push_back(8'h01); rd_q.push_back(8'h02);
      rd_q.push_back(8'h03); rd_q.push_back(8'h04);
      push_bus(32'h20, 1'b0, 8'h00); push_bus(32'h21, 1'b0, 8'h00);
      push_bus(32'h22, 1'b0, 8'h00); push_bus(32'h23, 1'b0, 8'h00);
      push_resp(1'b0, 1'b1, 32'h0403_0201, 4);
      issue(1'b1, 1'b0, 3'b010, 32'h20, 32'd0);
      load = 1'b1; data_type = 3'b000; address = 32'h300;
      @(negedge clock);
      load = 1'b0;
      wait_idle();
      repeat (3) @(negedge clock);
      check("read_data_hold2", read_data, 32'h0403_0201);
      check("stray_load_ignored", {31'd0, busy}, 32'd0);

      // Reset during the second byte of a word store.
      wait_cycles = 3;
      push_bus(32'h40, 1'b1, 8'h11);
      issue(1'b0, 1'b1, 3'b010, 32'h40, 32'h4433_2211);
      begin
         int n = 0;
         while (bus_q.size() != 0 && n < 50) begin
            @(posedge clock);
            n++;
         end
         check("reset_first_byte_seen", 32'(bus_q.size()), 32'd0);
      end
      #2 reset_n = 1'b0;
      #1;
      check("reset_drops_request", {31'd0, mem_request}, 32'd0);
      check("reset_clears_busy", {29'd0, busy, done, fault}, 32'd0);
      check("reset_clears_read", read_data, 32'd0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      wait_cycles = 0;

      repeat (6) @(negedge clock);
      check("queues_drained", 32'(bus_q.size() + resp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
